// File: rtl/audio_dma_sequencer.sv
// Audio playback sequencer: splits a track into DMA segments of at most pSegWords
// words, optionally looping, with graceful stop and start-configuration checking.
module audio_dma_sequencer #(
  parameter int pDmaAdrsWidth = 18,
  parameter int pSegWords     = 256
) (
  input  logic                     iSCLK,
  input  logic                     iSRST,
  input  logic                     iStart,
  input  logic                     iStop,
  input  logic                     iLoop,
  input  logic [pDmaAdrsWidth-1:0] iTrackStart,
  input  logic [pDmaAdrsWidth-1:0] iTrackEnd,
  output logic [pDmaAdrsWidth-1:0] oDmaAdrsStart,
  output logic [pDmaAdrsWidth-1:0] oDmaAdrsEnd,
  output logic                     oDmaEnable,
  input  logic                     iDmaDone,
  output logic                     oBusy,
  output logic [15:0]              oSegCnt,
  output logic [7:0]               oLoopCnt,
  output logic                     oDoneIrq,
  output logic                     oCfgErr
);

  localparam int W = pDmaAdrsWidth;
  localparam logic [W:0] SegSpan = (W+1)'(pSegWords - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_GAP} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   trk_start_q, trk_start_d;
  logic [W-1:0]   trk_end_q, trk_end_d;
  logic [W-1:0]   cur_q, cur_d;
  logic [W-1:0]   adrs_start_q, adrs_start_d;
  logic [W-1:0]   adrs_end_q, adrs_end_d;
  logic [15:0]    seg_cnt_q, seg_cnt_d;
  logic [7:0]     loop_cnt_q, loop_cnt_d;
  logic [1:0]     gap_cnt_q, gap_cnt_d;
  logic           stop_pend_q, stop_pend_d;
  logic           done_irq_q, done_irq_d;
  logic           cfg_err_q, cfg_err_d;
  logic           dma_done_q;
  logic           dma_rise;
  logic [W:0]     seg_sum;
  logic [W-1:0]   seg_last;

  assign dma_rise = iDmaDone & ~dma_done_q;

  // One extra bit keeps the segment end from wrapping near the top of memory.
  assign seg_sum  = {1'b0, cur_q} + SegSpan;
  assign seg_last = (seg_sum > {1'b0, trk_end_q}) ? trk_end_q : seg_sum[W-1:0];

  always_comb begin
    state_d      = state_q;
    trk_start_d  = trk_start_q;
    trk_end_d    = trk_end_q;
    cur_d        = cur_q;
    adrs_start_d = adrs_start_q;
    adrs_end_d   = adrs_end_q;
    seg_cnt_d    = seg_cnt_q;
    loop_cnt_d   = loop_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    stop_pend_d  = stop_pend_q;
    done_irq_d   = 1'b0;
    cfg_err_d    = cfg_err_q;

    if (iStop && (state_q != ST_IDLE)) stop_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          if (iTrackEnd >= iTrackStart) begin
            trk_start_d = iTrackStart;
            trk_end_d   = iTrackEnd;
            cur_d       = iTrackStart;
            seg_cnt_d   = '0;
            loop_cnt_d  = '0;
            cfg_err_d   = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        adrs_start_d = cur_q;
        adrs_end_d   = seg_last;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (dma_rise) begin
          seg_cnt_d = seg_cnt_q + 16'd1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        // Two quiet cycles, then the third GAP cycle makes the decision.
        if (gap_cnt_q != 2'd2) begin
          gap_cnt_d = gap_cnt_q + 2'd1;
        end else if ((adrs_end_q != trk_end_q) && !stop_pend_q) begin
          cur_d   = adrs_end_q + W'(1);
          state_d = ST_LOAD;
        end else if ((adrs_end_q == trk_end_q) && iLoop && !stop_pend_q) begin
          cur_d = trk_start_q;
          if (loop_cnt_q != 8'hFF) loop_cnt_d = loop_cnt_q + 8'd1;
          state_d = ST_LOAD;
        end else begin
          done_irq_d  = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      state_q      <= ST_IDLE;
      trk_start_q  <= '0;
      trk_end_q    <= '0;
      cur_q        <= '0;
      adrs_start_q <= '0;
      adrs_end_q   <= '0;
      seg_cnt_q    <= '0;
      loop_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      stop_pend_q  <= 1'b0;
      done_irq_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      dma_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      trk_start_q  <= trk_start_d;
      trk_end_q    <= trk_end_d;
      cur_q        <= cur_d;
      adrs_start_q <= adrs_start_d;
      adrs_end_q   <= adrs_end_d;
      seg_cnt_q    <= seg_cnt_d;
      loop_cnt_q   <= loop_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      stop_pend_q  <= stop_pend_d;
      done_irq_q   <= done_irq_d;
      cfg_err_q    <= cfg_err_d;
      dma_done_q   <= iDmaDone;
    end
  end

  assign oDmaAdrsStart = adrs_start_q;
  assign oDmaAdrsEnd   = adrs_end_q;
  assign oDmaEnable    = (state_q == ST_RUN);
  assign oBusy         = (state_q != ST_IDLE);
  assign oSegCnt       = seg_cnt_q;
  assign oLoopCnt      = loop_cnt_q;
  assign oDoneIrq      = done_irq_q;
  assign oCfgErr       = cfg_err_q;

endmodule

// File: tb/tb_audio_dma_sequencer.sv
// Directed self-checking bench for audio_dma_sequencer with hand-computed expectations.
module tb_audio_dma_sequencer;

  localparam int W = 18;

  logic         iSCLK = 1'b0;
  logic         iSRST = 1'b1;
  logic         iStart = 1'b0;
  logic         iStop = 1'b0;
  logic         iLoop = 1'b0;
  logic [W-1:0] iTrackStart = '0;
  logic [W-1:0] iTrackEnd = '0;
  logic [W-1:0] oDmaAdrsStart;
  logic [W-1:0] oDmaAdrsEnd;
  logic         oDmaEnable;
  logic         iDmaDone = 1'b0;
  logic         oBusy;
  logic [15:0]  oSegCnt;
  logic [7:0]   oLoopCnt;
  logic         oDoneIrq;
  logic         oCfgErr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int irqs;

  audio_dma_sequencer #(.pDmaAdrsWidth(W), .pSegWords(256)) dut (
    .iSCLK(iSCLK), .iSRST(iSRST), .iStart(iStart), .iStop(iStop), .iLoop(iLoop),
    .iTrackStart(iTrackStart), .iTrackEnd(iTrackEnd),
    .oDmaAdrsStart(oDmaAdrsStart), .oDmaAdrsEnd(oDmaAdrsEnd), .oDmaEnable(oDmaEnable),
    .iDmaDone(iDmaDone), .oBusy(oBusy), .oSegCnt(oSegCnt), .oLoopCnt(oLoopCnt),
    .oDoneIrq(oDoneIrq), .oCfgErr(oCfgErr)
  );

  always #5 iSCLK = ~iSCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iSCLK);
    #1;
  endtask

  task automatic start_track(input logic [W-1:0] s, input logic [W-1:0] e,
                             input logic lp, input logic stp);
    iTrackStart = s;
    iTrackEnd   = e;
    iLoop       = lp;
    iStart      = 1'b1;
    iStop       = stp;
    tick();
    iStart = 1'b0;
    iStop  = 1'b0;
    $display("start  track [0x%05h,0x%05h] loop=%0d stop=%0d", s, e, lp, stp);
  endtask

  task automatic done_edge();
    iDmaDone = 1'b1;
    tick();
    iDmaDone = 1'b0;
    $display("done   segment, seg_cnt=%0d", oSegCnt);
  endtask

  // Counts further cycles until the DMA is re-enabled, bounded.
  task automatic wait_enable(output int n);
    n = 0;
    while (!oDmaEnable && n < 20) begin
      tick();
      n++;
    end
    $display("enable seg [0x%05h,0x%05h] after %0d more cycles", oDmaAdrsStart, oDmaAdrsEnd, n);
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oDoneIrq) n++;
    end
    $display("drain  irqs=%0d busy=%0d", n, oBusy);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_adrs_start"}, 32'(oDmaAdrsStart), 32'h0);
    check_val({tag, "_adrs_end"},   32'(oDmaAdrsEnd),   32'h0);
    check_val({tag, "_enable"},     32'(oDmaEnable),    32'h0);
    check_val({tag, "_busy"},       32'(oBusy),         32'h0);
    check_val({tag, "_segcnt"},     32'(oSegCnt),       32'h0);
    check_val({tag, "_loopcnt"},    32'(oLoopCnt),      32'h0);
    check_val({tag, "_irq"},        32'(oDoneIrq),      32'h0);
    check_val({tag, "_cfgerr"},     32'(oCfgErr),       32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    iSRST = 1'b0;
    tick();

    // Two-segment track, no loop
    start_track(18'h00100, 18'h002FF, 1'b0, 1'b0);
    check_val("t1_load_busy", 32'(oBusy), 32'h1);
    check_val("t1_load_en", 32'(oDmaEnable), 32'h0);
    tick();
    check_val("t1_start_latency_en", 32'(oDmaEnable), 32'h1);
    check_val("t1_seg0_start", 32'(oDmaAdrsStart), 32'h100);
    check_val("t1_seg0_end", 32'(oDmaAdrsEnd), 32'h1FF);
    repeat (3) tick();
    check_val("t1_run_stable_end", 32'(oDmaAdrsEnd), 32'h1FF);
    done_edge();
    check_val("t1_gap_en", 32'(oDmaEnable), 32'h0);
    check_val("t1_segcnt1", 32'(oSegCnt), 32'h1);
    wait_enable(cyc);
    check_val("t1_done_latency", 32'(cyc + 1), 32'd5);
    check_val("t1_seg1_start", 32'(oDmaAdrsStart), 32'h200);
    check_val("t1_seg1_end", 32'(oDmaAdrsEnd), 32'h2FF);
    done_edge();
    drain(irqs);
    check_val("t1_irq_count", 32'(irqs), 32'd1);
    check_val("t1_busy_end", 32'(oBusy), 32'h0);
    check_val("t1_segcnt2", 32'(oSegCnt), 32'h2);

    // Rejected configuration
    start_track(18'h00200, 18'h001FF, 1'b0, 1'b0);
    check_val("t4_cfgerr", 32'(oCfgErr), 32'h1);
    check_val("t4_busy", 32'(oBusy), 32'h0);
    check_val("t4_en", 32'(oDmaEnable), 32'h0);
    tick();
    check_val("t4_idle_en", 32'(oDmaEnable), 32'h0);

    // Looping track, stop during the third segment
    start_track(18'h00000, 18'h000FF, 1'b1, 1'b0);
    check_val("t2_cfgerr_cleared", 32'(oCfgErr), 32'h0);
    check_val("t2_segcnt_cleared", 32'(oSegCnt), 32'h0);
    tick();
    check_val("t2_seg_end", 32'(oDmaAdrsEnd), 32'hFF);
    done_edge();
    wait_enable(cyc);
    check_val("t2_loop1", 32'(oLoopCnt), 32'd1);
    check_val("t2_reload_start", 32'(oDmaAdrsStart), 32'h0);
    done_edge();
    wait_enable(cyc);
    check_val("t2_loop2", 32'(oLoopCnt), 32'd2);
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    check_val("t2_stop_keeps_run", 32'(oDmaEnable), 32'h1);
    done_edge();
    drain(irqs);
    check_val("t2_irq_count", 32'(irqs), 32'd1);
    check_val("t2_busy_end", 32'(oBusy), 32'h0);
    check_val("t2_loop_final", 32'(oLoopCnt), 32'd2);
    check_val("t2_segcnt3", 32'(oSegCnt), 32'd3);

    // Segment at the top of memory
    start_track(18'h3FF80, 18'h3FFFF, 1'b0, 1'b0);
    tick();
    check_val("t3_seg_start", 32'(oDmaAdrsStart), 32'h3FF80);
    check_val("t3_seg_end", 32'(oDmaAdrsEnd), 32'h3FFFF);
    done_edge();
    drain(irqs);
    check_val("t3_irq_count", 32'(irqs), 32'd1);
    check_val("t3_segcnt", 32'(oSegCnt), 32'd1);
    check_val("t3_busy_end", 32'(oBusy), 32'h0);

    // Start ignored while running; held done counts once
    start_track(18'h00100, 18'h002FF, 1'b0, 1'b0);
    tick();
    iTrackStart = 18'h00000;
    iTrackEnd   = 18'h3FFFF;
    iStart      = 1'b1;
    tick();
    iStart = 1'b0;
    check_val("t5_ign_start", 32'(oDmaAdrsStart), 32'h100);
    check_val("t5_ign_end", 32'(oDmaAdrsEnd), 32'h1FF);
    check_val("t5_ign_segcnt", 32'(oSegCnt), 32'd0);
    iDmaDone = 1'b1;
    repeat (15) tick();
    check_val("t5_held_segcnt", 32'(oSegCnt), 32'd1);
    check_val("t5_held_en", 32'(oDmaEnable), 32'h1);
    check_val("t5_held_seg1", 32'(oDmaAdrsStart), 32'h200);
    iDmaDone = 1'b0;
    tick();
    done_edge();
    check_val("t5_segcnt2", 32'(oSegCnt), 32'd2);
    drain(irqs);
    check_val("t5_irq_count", 32'(irqs), 32'd1);
    check_val("t5_busy_end", 32'(oBusy), 32'h0);

    // Asynchronous reset mid-segment
    start_track(18'h00100, 18'h002FF, 1'b0, 1'b0);
    tick();
    check_val("t6_running", 32'(oDmaEnable), 32'h1);
    iSRST = 1'b1;
    #2;
    check_all_zero("t6_async");
    tick();
    iSRST = 1'b0;
    tick();
    done_edge();
    repeat (6) tick();
    check_all_zero("t6_after");

    // Stop in idle and simultaneous start+stop leave no stop pending
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    start_track(18'h00400, 18'h004FF, 1'b1, 1'b1);
    tick();
    done_edge();
    wait_enable(cyc);
    check_val("t7_loop_continues", 32'(oDmaEnable), 32'h1);
    check_val("t7_loopcnt", 32'(oLoopCnt), 32'd1);
    iLoop = 1'b0;
    done_edge();
    drain(irqs);
    check_val("t7_irq_count", 32'(irqs), 32'd1);
    check_val("t7_busy_end", 32'(oBusy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
